// File: rtl/fifo_arb_pkg.sv
// ==========================================================================
// fifo_arb_pkg : shared types/constants for the FIFO write arbiter. rev 1.0
// ==========================================================================
`default_nettype none

package fifo_arb_pkg;

  localparam int XFER_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ==========================================================================
// rr_picker : combinational round-robin search from a start index. rev 1.0
// ==========================================================================
`default_nettype none

module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_start,
  output logic                    o_found,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IW = $clog2(NREQ);

  // Walk from the farthest candidate back to i_start so the nearest hit wins.
  always_comb begin
    int pos;
    pos     = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(i_start) + k) % NREQ;
      if (i_req[pos]) begin
        o_found = 1'b1;
        o_idx   = IW'(pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ==========================================================================
// fifo_wr_arbiter : round-robin burst arbiter feeding one FIFO write port.
// rev 1.0
// ==========================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int DW    = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   req_valid,
  input  logic [NREQ*DW-1:0]                req_data,
  output logic [NREQ-1:0]                   req_ready,
  output logic [$clog2(NREQ)+DW-1:0]        fifo_din,
  output logic                              fifo_write,
  input  logic                              fifo_full,
  output logic [$clog2(NREQ)-1:0]           grant_id,
  output logic                              busy,
  output logic [fifo_arb_pkg::XFER_W-1:0]   xfer_cnt
);

  import fifo_arb_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  arb_state_t        r_state;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_last_owner;
  logic [BW-1:0]     r_beat_cnt;
  logic [XFER_W-1:0] r_xfer_cnt;

  logic              w_grant;
  logic              w_owner_valid;
  logic              w_write;
  logic              w_burst_end;
  logic              w_release;
  logic [NREQ-1:0]   w_owner_1h;
  logic [IW-1:0]     w_base;
  logic [IW-1:0]     w_start;
  logic [NREQ-1:0]   w_search_req;
  logic              w_found;
  logic [IW-1:0]     w_found_idx;

  // Outputs are gated by rst so a mid-burst reset cycle can never write.
  assign w_grant       = (r_state == ST_GRANT) && !rst;
  assign w_owner_valid = req_valid[r_owner];
  assign w_write       = w_grant && w_owner_valid && !fifo_full;
  assign w_burst_end   = (r_beat_cnt == BW'(BURST - 1));
  assign w_release     = w_grant && ((w_write && w_burst_end) || !w_owner_valid);
  assign w_owner_1h    = NREQ'(1) << r_owner;

  // In GRANT the search only matters on release, where last_owner becomes owner.
  assign w_base       = (r_state == ST_GRANT) ? r_owner : r_last_owner;
  assign w_start      = (w_base == IW'(NREQ - 1)) ? '0 : w_base + 1'b1;
  assign w_search_req = (r_state == ST_GRANT) ? (req_valid & ~w_owner_1h) : req_valid;

  rr_picker #(
    .NREQ    (NREQ)
  ) u_picker (
    .i_req   (w_search_req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_found_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IW'(NREQ - 1);
      r_beat_cnt   <= '0;
      r_xfer_cnt   <= '0;
    end else begin
      if (w_write) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner <= w_found_idx;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_last_owner <= r_owner;
            r_beat_cnt   <= '0;
            if (w_found) begin
              r_owner <= w_found_idx;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = w_grant;
  assign grant_id   = rst ? '0 : r_owner;
  assign req_ready  = (w_grant && !fifo_full) ? w_owner_1h : '0;
  assign fifo_write = w_write;
  assign fifo_din   = {r_owner, req_data[r_owner*DW +: DW]};
  assign xfer_cnt   = r_xfer_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ==========================================================================
// tb_fifo_wr_arbiter : directed self-checking bench for fifo_wr_arbiter.
// rev 1.0
// ==========================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int IW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [IW+DW-1:0]  fifo_din;
  logic              fifo_write;
  logic              fifo_full;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic [15:0]       xfer_cnt;

  int checks = 0;
  int errors = 0;
  int k[NREQ];
  int exp_xfer;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DW         (DW),
    .NREQ       (NREQ),
    .BURST      (BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_din   (fifo_din),
    .fifo_write (fifo_write),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy),
    .xfer_cnt   (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester i presents 8'h{i}0 + (number of its beats accepted so far).
  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'(i * 16 + k[i]);
  endtask

  // etag < 0: no write expected this cycle; egid < 0: grant_id not checked.
  task automatic cyc(input string tag, input int etag, input logic ebusy, input int egid);
    logic [IW+DW-1:0] ed;
    drive_data();
    #1;
    chk({tag, ".busy"}, busy, ebusy);
    chk({tag, ".write"}, fifo_write, etag >= 0);
    if (egid >= 0) chk({tag, ".gid"}, grant_id, egid);
    if (!ebusy || fifo_full) chk({tag, ".ready0"}, req_ready, 0);
    if (etag >= 0) begin
      ed = {IW'(etag), 8'(etag * 16 + k[etag])};
      chk({tag, ".din"}, fifo_din, ed);
      chk({tag, ".ready"}, req_ready, 1 << etag);
      k[etag]++;
      exp_xfer++;
    end
    tick();
    chk({tag, ".xfer"}, xfer_cnt, exp_xfer);
  endtask

  task automatic do_reset(input logic [NREQ-1:0] v);
    rst       = 1'b1;
    req_valid = v;
    fifo_full = 1'b0;
    foreach (k[i]) k[i] = 0;
    exp_xfer  = 0;
    drive_data();
    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.write", fifo_write, 0);
    chk("rst.ready", req_ready, 0);
    chk("rst.gid", grant_id, 0);
    chk("rst.xfer", xfer_cnt, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // All requesters valid: four-beat bursts rotate 0,1,2,3 with no gaps.
    do_reset(4'hF);
    cyc("A.idle", -1, 1'b0, -1);
    for (int b = 0; b < 16; b++) cyc("A.burst", b / 4, 1'b1, b / 4);
    chk("A.xfer16", xfer_cnt, 16);
    req_valid = 4'h0;
    cyc("A.drop", -1, 1'b1, 0);
    cyc("A.idle2", -1, 1'b0, -1);

    // Lone requester 2: burst of 4, one bubble, then 2 more beats.
    do_reset(4'b0100);
    cyc("B.idle", -1, 1'b0, -1);
    for (int b = 0; b < 4; b++) cyc("B.b1", 2, 1'b1, 2);
    cyc("B.bubble", -1, 1'b0, -1);
    for (int b = 0; b < 2; b++) cyc("B.b2", 2, 1'b1, 2);
    req_valid = 4'h0;
    cyc("B.drop", -1, 1'b1, 2);
    cyc("B.end", -1, 1'b0, -1);

    // Requester 1 drops after 2 beats; 3 takes over with a fresh burst.
    do_reset(4'b1010);
    cyc("C.idle", -1, 1'b0, -1);
    for (int b = 0; b < 2; b++) cyc("C.r1", 1, 1'b1, 1);
    req_valid = 4'b1000;
    cyc("C.drop", -1, 1'b1, 1);
    for (int b = 0; b < 4; b++) cyc("C.r3", 3, 1'b1, 3);
    req_valid = 4'h0;
    cyc("C.end", -1, 1'b0, -1);

    // FIFO full for 5 cycles mid-burst holds the owner and freezes counts.
    do_reset(4'b0001);
    cyc("D.idle", -1, 1'b0, -1);
    for (int b = 0; b < 2; b++) cyc("D.pre", 0, 1'b1, 0);
    fifo_full = 1'b1;
    for (int b = 0; b < 5; b++) cyc("D.full", -1, 1'b1, 0);
    fifo_full = 1'b0;
    for (int b = 0; b < 2; b++) cyc("D.post", 0, 1'b1, 0);
    req_valid = 4'h0;
    cyc("D.end", -1, 1'b0, -1);

    // Reset during beat 2 of requester 1: no write, then requester 0 first.
    do_reset(4'b0010);
    cyc("E.idle", -1, 1'b0, -1);
    cyc("E.beat1", 1, 1'b1, 1);
    rst       = 1'b1;
    req_valid = 4'b0011;
    drive_data();
    #1;
    chk("E.rst.write", fifo_write, 0);
    chk("E.rst.ready", req_ready, 0);
    chk("E.rst.busy", busy, 0);
    chk("E.rst.gid", grant_id, 0);
    exp_xfer = 0;
    tick();
    chk("E.rst.xfer", xfer_cnt, 0);
    rst = 1'b0;
    cyc("E.idle2", -1, 1'b0, -1);
    cyc("E.r0", 0, 1'b1, 0);

    // 65537 back-to-back writes wrap the 16-bit counter to 1.
    do_reset(4'hF);
    cyc("F.idle", -1, 1'b0, -1);
    repeat (65536) tick();
    chk("F.wrap0", xfer_cnt, 0);
    tick();
    chk("F.wrap1", xfer_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DW, default 8: data width of each requester.
REQ-002 Parameter NREQ, default 4: number of requesters, range 2..16.
REQ-003 Parameter BURST, default 4: maximum beats per grant, range 1..256.
REQ-004 Derived constant IW = $clog2(NREQ): width of the requester tag.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  NREQ  per-requester data-valid.
REQ-008 req_data  in  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW].
REQ-009 req_ready  out  NREQ  per-requester accept; a beat transfers when valid and ready are both high.
REQ-010 fifo_din  out  IW+DW  {tag, data} to the write port of the single-clock FIFO.
REQ-011 fifo_write  out  1  FIFO write strobe.
REQ-012 fifo_full  in  1  FIFO full flag.
REQ-013 grant_id  out  IW  current owner; meaningful only while busy is high.
REQ-014 busy  out  1  high in state GRANT.
REQ-015 xfer_cnt  out  16  total beats written; wraps modulo 2^16.

Function
REQ-016 The FSM shall have two states: IDLE and GRANT.
REQ-017 Round-robin search shall start at (last_owner+1) mod NREQ and select the first requester with req_valid high.
REQ-018 In IDLE, when any req_valid is high, the FSM shall register the selected owner and enter GRANT on the next edge, giving 1-cycle grant latency.
REQ-019 In IDLE, all req_ready bits and fifo_write shall be 0.
REQ-020 In GRANT, req_ready[owner] shall equal ~fifo_full, combinationally; every other req_ready bit shall be 0.
REQ-021 fifo_write shall equal req_valid[owner] & req_ready[owner].
REQ-022 fifo_din shall equal {owner, req_data[owner]}, with no register stage.
REQ-023 Each write shall increment beat_cnt and xfer_cnt by 1.
REQ-024 The grant shall release when a write occurs with beat_cnt == BURST-1, or when req_valid[owner] is low in GRANT; no write occurs in that second case.
REQ-025 On release, last_owner shall take the value of owner and beat_cnt shall clear to 0.
REQ-026 On release, the search shall run in the same cycle with the releasing owner excluded.
REQ-027 If the search finds a requester, the FSM shall stay in GRANT with the new owner, with no idle bubble.
REQ-028 If the search finds no requester, the FSM shall go to IDLE.
REQ-029 When only the releasing owner is valid, it shall be re-granted through IDLE, costing one bubble cycle.
REQ-030 While fifo_full is high in GRANT, the owner shall be held, beat_cnt and xfer_cnt shall freeze, and no timeout shall apply.
REQ-031 When a burst-end release and req_valid[owner] low fall in the same cycle, the burst-end rule shall govern, because a write implies valid.
REQ-032 With BURST=1, every write shall release the grant.
REQ-033 The arbiter shall never issue fifo_write while fifo_full is high.

Reset
REQ-034 While rst is high: state = IDLE, owner = 0, last_owner = NREQ-1 (so requester 0 has first priority), beat_cnt = 0, xfer_cnt = 0.
REQ-035 While rst is high, all combinational outputs shall follow from the reset state: req_ready = 0, fifo_write = 0, busy = 0, grant_id = 0.
REQ-036 A reset asserted mid-burst shall abort the burst with no write in the reset cycle; arbitration shall resume in the first cycle after rst deasserts.

Structure
REQ-037 Package fifo_arb_pkg shall hold the FSM state enum typedef and the xfer_cnt width constant (16).
REQ-038 Sub-module rr_picker (NREQ parameter) shall be combinational: inputs request vector and start index; outputs found flag and index.
REQ-039 The FIFO itself shall stay outside this block and connect only through fifo_din, fifo_write and fifo_full.

Verification
REQ-040 With NREQ=4, BURST=4 and fifo never full, the bench shall use data = 8'h{i}0+k for requester i.
REQ-041 Stimulus: all requesters held valid from reset release -> writes shall be tagged 0,0,0,0,1,1,1,1,2,... with no idle cycles between bursts, and xfer_cnt = 16 after 17 cycles.
REQ-042 Stimulus: only requester 2 valid for 6 beats -> 4 writes, 1 idle cycle, 2 writes, then IDLE; busy shall drop after the last write.
REQ-043 Stimulus: requester 1 drops valid after 2 beats while requester 3 is valid -> the grant shall move to 3 on the next cycle, and requester 1's beat_cnt shall not carry over.
REQ-044 Stimulus: fifo_full forced high for 5 cycles mid-burst -> req_ready = 0 and fifo_write = 0 for those 5 cycles, the owner shall be unchanged, and the burst shall finish its remaining beats afterwards.
REQ-045 Stimulus: rst pulsed during beat 2 of requester 1's burst -> the next grant shall go to requester 0 if valid, and xfer_cnt = 0.
REQ-046 Stimulus: drive 65537 writes -> xfer_cnt shall read 1.
